// File: rtl/hb_decimator_2.sv
// 11-tap half-band FIR with decimation by 2, 1s17 in/out. The pipeline is pre-add, multiply,
// then accumulate/round/saturate. Every 2nd accepted sample launches one output 3 clocks later.
module hb_decimator_2 #(
  parameter int unsigned OUT_PHASE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [17:0] data_in,
  output logic signed [17:0] data_out,
  output logic               out_valid
);

  localparam logic LAUNCH_PHASE = 1'(OUT_PHASE);

  // Only the non-zero, symmetric coefficients are stored.
  localparam logic signed [17:0] H0 = 18'sd1638;
  localparam logic signed [17:0] H2 = -18'sd9830;
  localparam logic signed [17:0] H4 = 18'sd40960;
  localparam logic signed [17:0] H5 = 18'sd65536;

  localparam logic signed [39:0] ROUND  = 40'sd65536;
  localparam logic signed [39:0] SAT_HI = 40'sd131071;
  localparam logic signed [39:0] SAT_LO = -40'sd131072;

  logic signed [17:0] taps [11];
  logic               phase;
  logic               launch;
  logic               launch_q;
  logic               s1_valid;
  logic               s2_valid;

  logic signed [18:0] pre_0;
  logic signed [18:0] pre_2;
  logic signed [18:0] pre_4;
  logic signed [17:0] mid;

  logic signed [36:0] prod_0;
  logic signed [36:0] prod_2;
  logic signed [36:0] prod_4;
  logic signed [36:0] prod_5;

  logic signed [39:0] acc;
  logic signed [39:0] rounded;
  logic signed [17:0] sat;

  assign launch = in_valid && (phase == LAUNCH_PHASE);

  // NOTE: the delay line is a register chain, not a RAM, so clearing it in reset is cheap.
  // Clearing it keeps the first outputs after reset free of stale samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 11; i++) taps[i] <= '0;
      phase <= 1'b0;
    end else if (in_valid) begin
      // NOTE: non-blocking assignments make every tap take its neighbour's old value.
      // With blocking assignments the chain would collapse in a single clock.
      taps[0] <= data_in;
      for (int i = 1; i < 11; i++) taps[i] <= taps[i-1];
      phase <= ~phase;
    end
  end

  // Valid tokens advance every clock. A later in_valid=0 therefore never stalls a launch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      launch_q <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      launch_q <= launch;
      s1_valid <= launch_q;
      s2_valid <= s1_valid;
    end
  end

  // Stage 1: fold the symmetric taps. The odd taps other than the centre are zero and are skipped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_0 <= '0;
      pre_2 <= '0;
      pre_4 <= '0;
      mid   <= '0;
    end else begin
      pre_0 <= 19'(taps[0]) + 19'(taps[10]);
      pre_2 <= 19'(taps[2]) + 19'(taps[8]);
      pre_4 <= 19'(taps[4]) + 19'(taps[6]);
      mid   <= taps[5];
    end
  end

  // Stage 2: full-precision products.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prod_0 <= '0;
      prod_2 <= '0;
      prod_4 <= '0;
      prod_5 <= '0;
    end else begin
      prod_0 <= 37'(pre_0) * 37'(H0);
      prod_2 <= 37'(pre_2) * 37'(H2);
      prod_4 <= 37'(pre_4) * 37'(H4);
      prod_5 <= 37'(mid) * 37'(H5);
    end
  end

  // Stage 3 arithmetic: sum, round half up, clamp to the 1s17 range.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path can infer a latch.
    sat     = rounded[17:0];
    acc     = 40'(prod_0) + 40'(prod_2) + 40'(prod_4) + 40'(prod_5);
    rounded = (acc + ROUND) >>> 17;
    if (rounded > SAT_HI) begin
      sat = 18'sh1FFFF;
    end else if (rounded < SAT_LO) begin
      sat = 18'sh20000;
    end else begin
      sat = rounded[17:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) data_out <= sat;
    end
  end

endmodule

// File: tb/tb_hb_decimator_2.sv
// Self-checking bench for hb_decimator_2. A sample-history model predicts each decimated output
// and the clock it is due on. Directed streams pin the model with literal values.
module tb_hb_decimator_2;

  localparam int     OUT_PHASE = 1;
  localparam longint P_MAX     = 131071;
  localparam longint N_MIN     = -131072;
  localparam longint ABSENT    = 64'sd1 << 40;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [17:0] data_in;
  logic signed [17:0] data_out;
  logic               out_valid;

  hb_decimator_2 #(.OUT_PHASE(OUT_PHASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .data_in  (data_in),
    .data_out (data_out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint due;
    longint y;
  } exp_t;

  longint coef [11] = '{1638, 0, -9830, 0, 40960, 65536, 40960, 0, -9830, 0, 1638};

  int     checks   = 0;
  int     failures = 0;
  longint cycle    = 0;
  bit     armed    = 1'b0;
  longint xs[$];
  exp_t   pend[$];
  longint last_y   = 0;
  longint seen[$];

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Direct convolution over everything accepted since reset; older than 10 samples contributes nothing.
  function automatic longint fir_out();
    longint acc = 0;
    longint y;
    int     n   = xs.size() - 1;
    for (int k = 0; k < 11; k++) begin
      if (n - k >= 0) acc += coef[k] * xs[n-k];
    end
    y = (acc + 65536) >>> 17;
    if (y > P_MAX) y = P_MAX;
    else if (y < N_MIN) y = N_MIN;
    return y;
  endfunction

  function automatic longint rnd18();
    logic signed [17:0] t;
    t = 18'($urandom);
    return longint'(t);
  endfunction

  function automatic longint rnd_data();
    case ($urandom_range(0, 7))
      0:       return P_MAX;
      1:       return N_MIN;
      default: return rnd18();
    endcase
  endfunction

  // One clock of stimulus, followed by the model's view of that edge.
  task automatic drive(input bit rst_n, input bit v, input longint d);
    @(negedge clk);
    reset    = rst_n;
    in_valid = v;
    data_in  = 18'(d);
    @(posedge clk);
    cycle++;
    if (!rst_n) begin
      xs.delete();
      pend.delete();
      last_y = 0;
      armed  = 1'b1;
    end else if (v) begin
      xs.push_back(d);
      if ((xs.size() - 1) % 2 == OUT_PHASE) pend.push_back('{cycle + 3, fir_out()});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0);
  endtask

  // The second reset edge also offers a valid sample, which reset must discard.
  task automatic do_reset();
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 12345);
    seen.delete();
  endtask

  task automatic stream(input longint s[$], input bit gapped);
    foreach (s[i]) begin
      drive(1'b1, 1'b1, s[i]);
      if (gapped) drive(1'b1, 1'b0, rnd18());
    end
    idle(8);
  endtask

  task automatic expect_seen(input string name, input int idx, input longint val);
    if (idx < seen.size()) check(name, seen[idx], val);
    else check({name, "_missing"}, ABSENT, val);
  endtask

  task automatic impulse_literals(input string tag);
    longint lit [7] = '{819, -4915, 20480, 20480, -4915, 819, 0};
    for (int i = 0; i < 7; i++) expect_seen($sformatf("%s_out%0d", tag, i), i, lit[i]);
  endtask

  function automatic void impulse_seq(output longint q[$]);
    q.delete();
    q.push_back(0);
    q.push_back(65536);
    for (int i = 0; i < 14; i++) q.push_back(0);
  endfunction

  // Every cycle: out_valid must match the model's schedule, and data_out must match the value or hold it.
  always @(negedge clk) begin
    bit exp_v;
    if (armed) begin
      exp_v = (pend.size() > 0) && (pend[0].due == cycle);
      if (out_valid === 1'b1) seen.push_back(longint'(data_out));
      check("out_valid", out_valid, exp_v);
      if (exp_v) begin
        check("data_out", data_out, pend[0].y);
        last_y = pend[0].y;
        void'(pend.pop_front());
      end else begin
        check("data_out_hold", data_out, last_y);
      end
    end
  end

  initial begin
    longint q[$];
    longint sat_pos [12];
    longint sat_neg [12];

    reset    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;

    do_reset();
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_data_out", data_out, 0);

    // Continuous impulse.
    impulse_seq(q);
    stream(q, 1'b0);
    impulse_literals("impulse");

    // Centre tap only.
    do_reset();
    q.delete();
    q.push_back(65536);
    for (int i = 0; i < 15; i++) q.push_back(0);
    stream(q, 1'b0);
    expect_seen("centre_out0", 0, 0);
    expect_seen("centre_out1", 1, 0);
    expect_seen("centre_out2", 2, 32768);
    expect_seen("centre_out3", 3, 0);

    // Impulse with in_valid toggling 1,0,1,0; timing is checked cycle by cycle.
    do_reset();
    impulse_seq(q);
    stream(q, 1'b1);
    impulse_literals("gapped");

    // DC extremes.
    do_reset();
    q.delete();
    for (int i = 0; i < 30; i++) q.push_back(P_MAX);
    stream(q, 1'b0);
    expect_seen("dc_pos_settled", seen.size() - 1, P_MAX);
    do_reset();
    q.delete();
    for (int i = 0; i < 30; i++) q.push_back(N_MIN);
    stream(q, 1'b0);
    expect_seen("dc_neg_settled", seen.size() - 1, N_MIN);

    // Saturation: the 6th launch (sample 11) sees the aligned pattern.
    sat_pos = '{0, P_MAX, 0, N_MIN, 0, P_MAX, P_MAX, P_MAX, 0, N_MIN, 0, P_MAX};
    sat_neg = '{0, N_MIN, 0, P_MAX, 0, N_MIN, N_MIN, N_MIN, 0, P_MAX, 0, N_MIN};
    do_reset();
    q.delete();
    foreach (sat_pos[i]) q.push_back(sat_pos[i]);
    stream(q, 1'b0);
    expect_seen("sat_pos", 5, P_MAX);
    do_reset();
    q.delete();
    foreach (sat_neg[i]) q.push_back(sat_neg[i]);
    stream(q, 1'b0);
    expect_seen("sat_neg", 5, N_MIN);

    // Reset one clock after a launch: in-flight results must vanish.
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, rnd18() | 64'sd4096);
    seen.delete();
    drive(1'b0, 1'b0, 0);
    idle(6);
    #1;
    check("midreset_pulses", seen.size(), 0);
    check("midreset_data_out", data_out, 0);
    impulse_seq(q);
    stream(q, 1'b0);
    impulse_literals("after_reset");

    // Random traffic with occasional resets, checked against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) drive(1'b0, 1'($urandom_range(0, 1)), rnd18());
      else drive(1'b1, $urandom_range(0, 9) < 7, rnd_data());
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
